hex_readback_decoder: RTL
=========================

Name: hex_readback_decoder

Overview:
- Inverse of the board's hex-to-seven-segment encoding path.
- Snapshots a bank of seven-segment digit patterns, then decodes them back into a packed hex value, one digit per clock.
- Flags any pattern that is not a legal hex glyph.
- Used on-board as a self-check monitor on the registered hex display buses, e.g. to confirm the A/B displays match the operand registers, with a valid/ack handshake to the consumer.

Parameters:
- DIGITS, 4: number of seven-segment digits in the bank (1..8).
- ACTIVE_LOW, 1: 1 = segment lit when bit is 0 (board convention); 0 = segment lit when bit is 1.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  request a capture/decode; honoured only in IDLE.
- SegBus  input  7*DIGITS  digit k occupies bits [7k+6:7k]; bit order {g,f,e,d,c,b,a}; digit 0 is least significant.
- Ack  input  1  consumer accepts result; meaningful only while Valid=1.
- Busy  output  1  high in SCAN state.
- Valid  output  1  high in DONE state; result stable.
- Value  output  4*DIGITS  decoded value; nibble k from digit k.
- ErrMask  output  DIGITS  bit k set if digit k pattern was illegal.
- AnyErr  output  1  OR-reduction of registered ErrMask.

Behaviour:
- Reset is synchronous: Reset=0 at an edge forces state IDLE and sets Busy=0, Valid=0, Value=0, ErrMask=0, digit index=0, snapshot=0. This applies in any state, including mid-SCAN and DONE.
- Reset overrides Start and Ack in the same cycle.
- FSM states: IDLE, SCAN, DONE.
- IDLE + Start=1:
  - latch SegBus into the snapshot register;
  - clear Value and ErrMask;
  - index <= 0;
  - go to SCAN.
- SCAN, each cycle, decode snapshot digit[index]:
  - write the nibble to Value[4*index+3:4*index];
  - write the error flag to ErrMask[index];
  - index increments.
- SCAN exit: the cycle that decodes index DIGITS-1 transitions to DONE.
- Start during SCAN or DONE is ignored (no restart, no re-snapshot).
- SegBus changes after the Start edge have no effect on the current result.
- DONE: Valid=1; Value and ErrMask held until Ack=1 is sampled, then IDLE on the next edge.
- Start asserted in the same cycle as the accepting Ack is ignored; a new Start is required in IDLE.
- Latency: Start sampled at edge t:
  - Busy=1 from t through t+DIGITS;
  - Valid=1 from edge t+DIGITS+1.
  - Minimum Start-to-Start throughput is DIGITS+3 cycles.
- Decode table (active-low form, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- ACTIVE_LOW=0: the pattern is bitwise-inverted before lookup.
- Illegal pattern (anything else, including all-off): nibble=0, ErrMask bit=1.
- AnyErr is combinational from the ErrMask register; no added latency.
- Index counter width is clog2(DIGITS), minimum 1 bit; it never exceeds DIGITS-1 and returns to 0 on Start.

Test Plan:
- Reset=0 for 1 cycle while in SCAN -> next edge: Busy=0, Valid=0, Value=16'h0000, ErrMask=4'b0000, state IDLE.
- SegBus = digits {3,C,5,A} (digit3..0), Start pulse at edge 0 -> Busy=1 edges 0..4, Valid=1 at edge 5, Value=16'h3C5A, ErrMask=0, AnyErr=0.
- Digits {1,0,illegal 1111111,1} -> Value=16'h1001, ErrMask=4'b0010, AnyErr=1; second case digit2=0110110 -> ErrMask=4'b0100.
- Start with SegBus={F,F,F,F}, SegBus changed to all-8 on the following cycle -> Value=16'hFFFF.
- Start re-pulsed during SCAN and DONE -> no restart, Valid timing unchanged. Ack held low 10 cycles -> Valid stays 1 with Value stable. Ack=1 together with Start -> IDLE, no new scan. Start next cycle -> new result after 5 cycles.
- ACTIVE_LOW=0 build, SegBus={~E,~d,~b,~0} in active-high form -> Value=16'hEDB0, ErrMask=0.

Source files
------------

// File: rtl/hex_readback_decoder.sv
// Snapshots a bank of seven-segment patterns and decodes them back to a packed
// hex value, one digit per clock, flagging patterns that are not hex glyphs.
module hex_readback_decoder #(
    parameter int DIGITS     = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [7*DIGITS-1:0] SegBus,
    input  logic                Ack,
    output logic                Busy,
    output logic                Valid,
    output logic [4*DIGITS-1:0] Value,
    output logic [DIGITS-1:0]   ErrMask,
    output logic                AnyErr,
    output logic [1:0]          fsm_state
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [7*DIGITS-1:0] snap;
    logic [IW-1:0]       index;
    logic [6:0]          cur_seg;
    logic [6:0]          lookup;
    logic [3:0]          cur_nib;
    logic                cur_err;

    always_comb begin
        cur_seg = 7'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IW'(i)) cur_seg = snap[7*i +: 7];
        end
    end

    // The table is written in active-low form; active-high buses are inverted first.
    assign lookup = ACTIVE_LOW ? cur_seg : ~cur_seg;

    always_comb begin
        cur_err = 1'b0;
        cur_nib = 4'h0;
        case (lookup)
            7'b1000000: cur_nib = 4'h0;
            7'b1111001: cur_nib = 4'h1;
            7'b0100100: cur_nib = 4'h2;
            7'b0110000: cur_nib = 4'h3;
            7'b0011001: cur_nib = 4'h4;
            7'b0010010: cur_nib = 4'h5;
            7'b0000010: cur_nib = 4'h6;
            7'b1111000: cur_nib = 4'h7;
            7'b0000000: cur_nib = 4'h8;
            7'b0010000: cur_nib = 4'h9;
            7'b0001000: cur_nib = 4'hA;
            7'b0000011: cur_nib = 4'hB;
            7'b1000110: cur_nib = 4'hC;
            7'b0100001: cur_nib = 4'hD;
            7'b0000110: cur_nib = 4'hE;
            7'b0001110: cur_nib = 4'hF;
            default:    cur_err = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Valid   <= 1'b0;
            Value   <= '0;
            ErrMask <= '0;
            index   <= '0;
            snap    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        snap    <= SegBus;
                        Value   <= '0;
                        ErrMask <= '0;
                        index   <= '0;
                        Busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    Value[4*index +: 4] <= cur_nib;
                    ErrMask[index]      <= cur_err;
                    if (index == LAST) state <= DONE;
                    else               index <= index + 1'b1;
                end
                DONE: begin
                    // First DONE cycle lets the last nibble settle before Valid rises.
                    if (!Valid) begin
                        Valid <= 1'b1;
                        Busy  <= 1'b0;
                    end else if (Ack) begin
                        Valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign AnyErr    = |ErrMask;
    assign fsm_state = state;

endmodule
